// File: rtl/ram2_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram2_arb_pkg
// Shared constants and types for the two-requester RAM port arbiter.
//   NREQ, DW_DEF, AW_DEF, RD_LAT_DEF : default sizing of the arbiter slice
//   req_id_e                         : requester id encoding (REQ0 / REQ1)
//   rd_tag_t                         : read-return tag {vld, id, fwd, fdata}
// ---------------------------------------------------------------------------
package ram2_arb_pkg;

   localparam int NREQ       = 2;
   localparam int DW_DEF     = 8;
   localparam int AW_DEF     = 8;
   localparam int RD_LAT_DEF = 2;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   // The forwarded data field is sized for the default data width.
   // Wider or narrower builds are zero-extended or truncated at the boundary.
   typedef struct packed {
      logic              vld;
      req_id_e           id;
      logic              fwd;
      logic [DW_DEF-1:0] fdata;
   } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the request
// and the last-granted pointer. Under contention the requester that was not
// granted last wins. The pointer follows every grant.
//   clk  in  1  clock
//   rst  in  1  asynchronous reset, active-high; forces gnt to 0 and clears
//               the pointer
//   req  in  2  request, bit i belongs to requester i
//   gnt  out 2  grant, one-hot or zero
// ---------------------------------------------------------------------------
module rr_arb2
   import ram2_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_e ptr_q;
   req_id_e ptr_d;

   // Grant selection. A lone requester is granted at once, so it sees no
   // bubble. Contention goes to whichever side did not win last time. A
   // cleared pointer therefore hands the first contention to requester 1.
   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (!rst) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == REQ1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
      if (gnt[1]) begin
         ptr_d = REQ1;
      end else if (gnt[0]) begin
         ptr_d = REQ0;
      end
   end

   // Last-granted pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= REQ0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram2_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram2_port_arbiter
// Shares one simple dual-port RAM (one write port, one registered read port)
// between two requesters. Each RAM port has its own round-robin arbiter, so
// one write and one read can issue per cycle. Read returns are tagged by a
// shift register whose depth matches the RAM read latency.
//
// Optional build macro: RAM2_ARB_RAW_FWD_EN
//   When defined, a read that reaches the RAM on the same edge as a write to
//   the same address returns the new write data instead of the RAM output.
//
// Ports:
//   sclk          in  1      clock (also the RAM read/write clock)
//   srst          in  1      asynchronous reset, active-high
//   wr_req        in  2      write requests
//   wr_addr       in  2*AW   write addresses, requester i at [i*AW +: AW]
//   wr_data       in  2*DW   write data, requester i at [i*DW +: DW]
//   wr_gnt        out 2      write grant, one-hot or zero
//   rd_req        in  2      read requests
//   rd_addr       in  2*AW   read addresses, requester i at [i*AW +: AW]
//   rd_gnt        out 2      read grant, one-hot or zero
//   rd_valid      out 2      read-return strobe, one-hot or zero
//   rd_data       out DW     read-return data (holds when rd_valid is 0)
//   ram_data      out DW     RAM write data
//   ram_wraddress out AW     RAM write address
//   ram_wren      out 1      RAM write enable
//   ram_rdaddress out AW     RAM read address
//   ram_q         in  DW     RAM read data
// ---------------------------------------------------------------------------
module ram2_port_arbiter
   import ram2_arb_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic [1:0]      wr_req,
   input  logic [2*AW-1:0] wr_addr,
   input  logic [2*DW-1:0] wr_data,
   output logic [1:0]      wr_gnt,
   input  logic [1:0]      rd_req,
   input  logic [2*AW-1:0] rd_addr,
   output logic [1:0]      rd_gnt,
   output logic [1:0]      rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic [DW-1:0]   ram_data,
   output logic [AW-1:0]   ram_wraddress,
   output logic            ram_wren,
   output logic [AW-1:0]   ram_rdaddress,
   input  logic [DW-1:0]   ram_q
);

   logic                ram_wren_q, ram_wren_d;
   logic [AW-1:0]       ram_wraddress_q, ram_wraddress_d;
   logic [DW-1:0]       ram_data_q, ram_data_d;
   logic [AW-1:0]       ram_rdaddress_q, ram_rdaddress_d;
   logic [DW-1:0]       rd_data_q, rd_data_d;
   rd_tag_t [RD_LAT:0]  tag_q;
   rd_tag_t [RD_LAT:0]  tag_d;
   rd_tag_t             ret_tag;

   rr_arb2 u_wr_arb (
      .clk (sclk),
      .rst (srst),
      .req (wr_req),
      .gnt (wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk (sclk),
      .rst (srst),
      .req (rd_req),
      .gnt (rd_gnt)
   );

   // Write port: a grant loads the winner's address and data for the next
   // cycle. Address and data hold when idle, and the enable pulses only for
   // a granted write.
   always_comb begin
      ram_wren_d      = 1'b0;
      ram_wraddress_d = ram_wraddress_q;
      ram_data_d      = ram_data_q;
      if (wr_gnt[1]) begin
         ram_wren_d      = 1'b1;
         ram_wraddress_d = wr_addr[AW +: AW];
         ram_data_d      = wr_data[DW +: DW];
      end else if (wr_gnt[0]) begin
         ram_wren_d      = 1'b1;
         ram_wraddress_d = wr_addr[0 +: AW];
         ram_data_d      = wr_data[0 +: DW];
      end
   end

   // Read port and tag pipeline. Stage 0 lines up with the cycle in which
   // ram_rdaddress is presented. Stage RD_LAT lines up with the cycle in
   // which ram_q carries that read's data.
   always_comb begin
      ram_rdaddress_d = ram_rdaddress_q;
      if (rd_gnt[1]) begin
         ram_rdaddress_d = rd_addr[AW +: AW];
      end else if (rd_gnt[0]) begin
         ram_rdaddress_d = rd_addr[0 +: AW];
      end

      tag_d        = '0;
      tag_d[0].vld = |rd_gnt;
      tag_d[0].id  = rd_gnt[1] ? REQ1 : REQ0;
      for (int i = 1; i <= RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
`ifdef RAM2_ARB_RAW_FWD_EN
      // Stage 0 valid means the RAM samples this read on the coming edge.
      // If the registered write hits the same address on that edge, keep
      // the new data with the tag.
      if (tag_q[0].vld && ram_wren_q && (ram_wraddress_q == ram_rdaddress_q)) begin
         tag_d[1].fwd   = 1'b1;
         tag_d[1].fdata = DW_DEF'(ram_data_q);
      end
`endif
   end

   // Return side. rd_data is live when the last tag stage is valid and
   // otherwise repeats the last returned value.
   always_comb begin
      ret_tag   = tag_q[RD_LAT];
      rd_valid  = 2'b00;
      rd_data_d = rd_data_q;
      if (ret_tag.vld) begin
         rd_valid  = (ret_tag.id == REQ1) ? 2'b10 : 2'b01;
         rd_data_d = ret_tag.fwd ? DW'(ret_tag.fdata) : ram_q;
      end
   end

   // State registers. Reset flushes in-flight read tags and drops a pending
   // write enable at once.
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         ram_wren_q      <= 1'b0;
         ram_wraddress_q <= '0;
         ram_data_q      <= '0;
         ram_rdaddress_q <= '0;
         rd_data_q       <= '0;
         tag_q           <= '0;
      end else begin
         ram_wren_q      <= ram_wren_d;
         ram_wraddress_q <= ram_wraddress_d;
         ram_data_q      <= ram_data_d;
         ram_rdaddress_q <= ram_rdaddress_d;
         rd_data_q       <= rd_data_d;
         tag_q           <= tag_d;
      end
   end

   assign ram_wren      = ram_wren_q;
   assign ram_wraddress = ram_wraddress_q;
   assign ram_data      = ram_data_q;
   assign ram_rdaddress = ram_rdaddress_q;
   assign rd_data       = rd_data_d;

endmodule

// File: doc/ram2_port_arbiter.md
Name: ram2_port_arbiter

Overview:
- Shares one simple dual-port RAM (`ram2_port`: 8-bit data, 8-bit address, one write port, one read port, registered read) between two requesters, 0 and 1.
- The write port and the read port each have their own round-robin arbiter, so one write and one read can be issued per cycle.
- Read data comes back through a latency-matched tag pipeline that marks which requester each beat belongs to.
- Sits between the client logic and the RAM instance; both RAM clocks are tied to `sclk`.

Parameters:
- DW, 8, data width.
- AW, 8, address width.
- RD_LAT, 2, cycles from `ram_rdaddress` being driven to `ram_q` valid; must be ≥1.

Ports:
- sclk  in  1  system clock; also drives the RAM rdclock and wrclock.
- srst  in  1  asynchronous reset, active-high.
- wr_req  in  2  per-requester write request, bit i belongs to requester i.
- wr_addr  in  2*AW  write addresses; requester i uses slice [i*AW +: AW].
- wr_data  in  2*DW  write data; requester i uses slice [i*DW +: DW].
- wr_gnt  out  2  write grant, one-hot or zero.
- rd_req  in  2  per-requester read request.
- rd_addr  in  2*AW  read addresses.
- rd_gnt  out  2  read grant, one-hot or zero.
- rd_valid  out  2  read-return strobe, one-hot or zero.
- rd_data  out  DW  read-return data, shared by both requesters.
- ram_data  out  DW  to RAM data.
- ram_wraddress  out  AW  to RAM wraddress.
- ram_wren  out  1  to RAM wren.
- ram_rdaddress  out  AW  to RAM rdaddress.
- ram_q  in  DW  from RAM q.

Behaviour:
- Reset: all registered outputs, the tag pipeline and both round-robin pointers clear to 0. `wr_gnt`, `rd_gnt` and `rd_valid` read 0 while `srst` is high.
- Handshake: a requester holds its req, addr and data stable until it sees its gnt bit high on a rising edge. The transfer is accepted on that edge.
- Grants are combinational from req and the pointer; no bubble when only one requester is active.
- Arbitration, applied to each port independently:
  - Both requesting: grant the requester that is not the port's last-granted one.
  - Pointer updates to the granted index on every grant.
  - After reset the pointer is 0, so requester 1 wins the first contention.
- Write path: a grant in cycle T registers `ram_wren`=1 plus address and data for cycle T+1. `ram_wren` is 0 in any cycle without a granted write.
- Read path:
  - A grant in cycle T registers `ram_rdaddress` for cycle T+1.
  - A tag {valid, id} enters an RD_LAT+1-deep shift register.
  - `rd_valid[id]`=1 and `rd_data`=`ram_q` in cycle T+1+RD_LAT; this is T+3 at default.
  - `rd_data` is don't-care when `rd_valid` is 0; it holds its last value, with no forced zero.
- Throughput: back-to-back grants to the same requester are allowed when the other is idle. A read can be accepted every cycle, with no stall.
- Ordering: returns arrive in grant order; there is no reordering.
- `ram_rdaddress` holds its last value when idle.
- Boundaries:
  - Address wrap (0xFF → 0x00) needs no special handling.
  - A simultaneous read and write from the same requester are independent.
- Reset mid-operation: the tag pipeline is flushed, in-flight reads never return, and any pending `ram_wren` drops immediately.

Optional Feature:
- Macro: RAM2_ARB_RAW_FWD_EN.
- Defined:
  - Applies when a write and a read reach the RAM on the same edge with `ram_wraddress`==`ram_rdaddress`.
  - The tag for that read carries a forward flag and the write data.
  - At return, `rd_data` = the forwarded write data (new data) instead of `ram_q`.
- Undefined: no forwarding. `rd_data` = `ram_q`, which is old or undefined per the RAM's mixed-port behaviour.

Decomposition:
- Package `ram2_arb_pkg`:
  - Constants NREQ=2, DW_DEF=8, AW_DEF=8, RD_LAT_DEF=2.
  - Requester id encoding REQ0=0, REQ1=1.
  - Tag struct {vld, id, fwd, fdata}.
- Sub-module `rr_arb2`: two-input round-robin arbiter with req[1:0], gnt[1:0] and an internal pointer. Instantiated twice, once for writes and once for reads.

Test Plan:
- Single write, then read: write 0xA5 to address 0x10 via requester 0 in cycle 2; read 0x10 via requester 1 in cycle 5 → `rd_valid`=2'b10 in cycle 8 with `rd_data`=0xA5.
- Write contention: both write requests held from reset release → grants alternate 1,0,1,0; the `ram_wren` data sequence matches the granted requester each cycle.
- Streaming reads: requester 0 reads addresses 0..7 on consecutive cycles → 8 consecutive `rd_valid`=2'b01 beats starting 3 cycles after the first grant, data in address order.
- Same-address collision: write 0x3C to address 0x20 (old value 0x11) on the same cycle as a read of 0x20 → with the macro, 0x3C returned; without it, 0x11 or X accepted, with no assertion.
- Reset mid-read: assert `srst` one cycle after a read grant → no `rd_valid` ever pulses for that read, `ram_wren`=0, and the first post-reset contention grants requester 1.
- Idle: no requests for 20 cycles → `ram_wren`=0, `wr_gnt`=`rd_gnt`=`rd_valid`=0 throughout.
